// File: rtl/ctrl_pkg.sv
// Shared opcode map, ALUOp codes, select encodings and the ID/EX control bundle
// for the pipelined MIPS main-control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_MUL    = 6'b011100;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] ALU_RTYPE = 6'b000010;
  localparam logic [5:0] ALU_BGEZ  = 6'b100001;
  localparam logic [5:0] ALU_BEQ   = 6'b100010;
  localparam logic [5:0] ALU_BNE   = 6'b100011;
  localparam logic [5:0] ALU_BLEZ  = 6'b100100;
  localparam logic [5:0] ALU_BGTZ  = 6'b100101;
  localparam logic [5:0] ALU_LUI   = 6'b100110;
  localparam logic [5:0] ALU_ADDU  = 6'b001000;
  localparam logic [5:0] ALU_ADDI  = 6'b000100;
  localparam logic [5:0] ALU_SLTI  = 6'b000110;
  localparam logic [5:0] ALU_SLTIU = 6'b001010;
  localparam logic [5:0] ALU_ANDI  = 6'b001001;
  localparam logic [5:0] ALU_ORI   = 6'b001011;
  localparam logic [5:0] ALU_XORI  = 6'b000111;
  localparam logic [5:0] ALU_MUL   = 6'b000101;

  localparam logic [2:0] LSEL_LW  = 3'b000;
  localparam logic [2:0] LSEL_LH  = 3'b001;
  localparam logic [2:0] LSEL_LB  = 3'b010;
  localparam logic [2:0] LSEL_LHU = 3'b011;
  localparam logic [2:0] LSEL_LBU = 3'b100;

  localparam logic [1:0] SSEL_SW = 2'b00;
  localparam logic [1:0] SSEL_SH = 2'b01;
  localparam logic [1:0] SSEL_SB = 2'b10;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_R31 = 2'b10
  } regdst_e;

  typedef struct packed {
    regdst_e     regdst;
    logic [5:0]  aluop;
    logic [2:0]  lsel;
    logic [1:0]  ssel;
    logic        jump;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic        wrdatasel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = ctrl_bundle_t'('0);

  function automatic ctrl_bundle_t load_ctrl(input logic [2:0] lsel);
    ctrl_bundle_t c;
    c          = BUBBLE;
    c.aluop    = ALU_ADDU;
    c.lsel     = lsel;
    c.memread  = 1'b1;
    c.memtoreg = 1'b1;
    c.alusrc   = 1'b1;
    c.regwrite = 1'b1;
    return c;
  endfunction

  function automatic ctrl_bundle_t store_ctrl(input logic [1:0] ssel);
    ctrl_bundle_t c;
    c          = BUBBLE;
    c.aluop    = ALU_ADDU;
    c.ssel     = ssel;
    c.memwrite = 1'b1;
    c.alusrc   = 1'b1;
    return c;
  endfunction

  // Immediate-operand ALU ops (including lui) write rt from ALU result.
  function automatic ctrl_bundle_t imm_ctrl(input logic [5:0] aluop);
    ctrl_bundle_t c;
    c          = BUBBLE;
    c.aluop    = aluop;
    c.alusrc   = 1'b1;
    c.regwrite = 1'b1;
    return c;
  endfunction

  function automatic ctrl_bundle_t branch_ctrl(input logic [5:0] aluop);
    ctrl_bundle_t c;
    c        = BUBBLE;
    c.aluop  = aluop;
    c.branch = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main-control decode: opcode to control bundle, plus whether the
// instruction reads rt (used by load-use detection).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   i_op,
  output ctrl_bundle_t o_ctrl,
  output logic         o_uses_rt
);

  always_comb begin
    o_ctrl    = BUBBLE;
    o_uses_rt = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.regdst   = RD_RD;
        o_ctrl.aluop    = ALU_RTYPE;
        o_ctrl.regwrite = 1'b1;
        o_uses_rt       = 1'b1;
      end
      OP_REGIMM: o_ctrl = branch_ctrl(ALU_BGEZ);
      OP_J:      o_ctrl.jump = 1'b1;
      OP_JAL: begin
        o_ctrl.regdst    = RD_R31;
        o_ctrl.jump      = 1'b1;
        o_ctrl.regwrite  = 1'b1;
        o_ctrl.wrdatasel = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl    = branch_ctrl(ALU_BEQ);
        o_uses_rt = 1'b1;
      end
      OP_BNE: begin
        o_ctrl    = branch_ctrl(ALU_BNE);
        o_uses_rt = 1'b1;
      end
      OP_BLEZ:  o_ctrl = branch_ctrl(ALU_BLEZ);
      OP_BGTZ:  o_ctrl = branch_ctrl(ALU_BGTZ);
      OP_ADDI:  o_ctrl = imm_ctrl(ALU_ADDI);
      OP_ADDIU: o_ctrl = imm_ctrl(ALU_ADDU);
      OP_SLTI:  o_ctrl = imm_ctrl(ALU_SLTI);
      OP_SLTIU: o_ctrl = imm_ctrl(ALU_SLTIU);
      OP_ANDI:  o_ctrl = imm_ctrl(ALU_ANDI);
      OP_ORI:   o_ctrl = imm_ctrl(ALU_ORI);
      OP_XORI:  o_ctrl = imm_ctrl(ALU_XORI);
      OP_LUI:   o_ctrl = imm_ctrl(ALU_LUI);
      OP_MUL: begin
        o_ctrl.regdst   = RD_RD;
        o_ctrl.aluop    = ALU_MUL;
        o_ctrl.regwrite = 1'b1;
        o_uses_rt       = 1'b1;
      end
      OP_LB:  o_ctrl = load_ctrl(LSEL_LB);
      OP_LH:  o_ctrl = load_ctrl(LSEL_LH);
      OP_LW:  o_ctrl = load_ctrl(LSEL_LW);
      OP_LBU: o_ctrl = load_ctrl(LSEL_LBU);
      OP_LHU: o_ctrl = load_ctrl(LSEL_LHU);
      OP_SB: begin
        o_ctrl    = store_ctrl(SSEL_SB);
        o_uses_rt = 1'b1;
      end
      OP_SH: begin
        o_ctrl    = store_ctrl(SSEL_SH);
        o_uses_rt = 1'b1;
      end
      OP_SW: begin
        o_ctrl    = store_ctrl(SSEL_SW);
        o_uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control register with load-use stall, branch/jump flush and
// multi-cycle multiply hold for the 5-stage MIPS pipeline.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 6,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         InstructionOp,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic               BranchTaken,
  output logic [1:0]         EX_RegDst,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [2:0]         EX_Lsel,
  output logic [1:0]         EX_Ssel,
  output logic               EX_Jump,
  output logic               EX_Branch,
  output logic               EX_MemRead,
  output logic               EX_MemtoReg,
  output logic               EX_MemWrite,
  output logic               EX_ALUSrc,
  output logic               EX_RegWrite,
  output logic               EX_WriteDataSel,
  output logic [REG_W-1:0]   EX_DestReg,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFIDFlush,
  output logic               EXHold
);

  localparam int CNT_W = 4;

  ctrl_bundle_t     w_dec;
  logic             w_uses_rt;
  logic [REG_W-1:0] w_dest;
  logic             w_mul_busy;
  logic             w_load_use;

  ctrl_bundle_t     r_ctrl;
  logic [REG_W-1:0] r_dest;
  logic [CNT_W-1:0] r_cnt;

  ctrl_decode u_decode (
    .i_op      (InstructionOp),
    .o_ctrl    (w_dec),
    .o_uses_rt (w_uses_rt)
  );

  always_comb begin
    w_dest = ID_Rt;
    case (w_dec.regdst)
      RD_RD:   w_dest = ID_Rd;
      RD_R31:  w_dest = REG_W'(31);
      default: w_dest = ID_Rt;
    endcase
  end

  assign w_mul_busy = (r_cnt != '0);
  // A load writing $0 never produces a value anyone waits for.
  assign w_load_use = r_ctrl.memread && (r_dest != '0) &&
                      ((r_dest == ID_Rs) || (w_uses_rt && (r_dest == ID_Rt)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ctrl <= BUBBLE;
      r_dest <= '0;
      r_cnt  <= '0;
    end else if (w_mul_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_dest <= w_dest;
      if (BranchTaken || w_load_use) begin
        r_ctrl <= BUBBLE;
      end else begin
        r_ctrl <= w_dec;
        if (InstructionOp == OP_MUL) r_cnt <= CNT_W'(MUL_CYCLES - 1);
      end
    end
  end

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    EXHold    = 1'b0;
    if (Rst) begin
      PCWrite = 1'b1;
    end else if (w_mul_busy) begin
      EXHold    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
    end else if (w_load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (w_dec.jump) begin
      IFIDFlush = 1'b1;
    end
  end

  assign EX_RegDst       = r_ctrl.regdst;
  assign EX_ALUOp        = ALUOP_W'(r_ctrl.aluop);
  assign EX_Lsel         = r_ctrl.lsel;
  assign EX_Ssel         = r_ctrl.ssel;
  assign EX_Jump         = r_ctrl.jump;
  assign EX_Branch       = r_ctrl.branch;
  assign EX_MemRead      = r_ctrl.memread;
  assign EX_MemtoReg     = r_ctrl.memtoreg;
  assign EX_MemWrite     = r_ctrl.memwrite;
  assign EX_ALUSrc       = r_ctrl.alusrc;
  assign EX_RegWrite     = r_ctrl.regwrite;
  assign EX_WriteDataSel = r_ctrl.wrdatasel;
  assign EX_DestReg      = r_dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (MUL_CYCLES=4 main instance,
// MUL_CYCLES=1 companion instance for the no-stall multiply case).
module tb_pipe_ctrl_unit;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] InstructionOp;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic       BranchTaken;

  logic [1:0] EX_RegDst;
  logic [5:0] EX_ALUOp;
  logic [2:0] EX_Lsel;
  logic [1:0] EX_Ssel;
  logic       EX_Jump, EX_Branch, EX_MemRead, EX_MemtoReg, EX_MemWrite;
  logic       EX_ALUSrc, EX_RegWrite, EX_WriteDataSel;
  logic [4:0] EX_DestReg;
  logic       PCWrite, IFIDWrite, IFIDFlush, EXHold;

  logic [1:0] m1_RegDst;
  logic [5:0] m1_ALUOp;
  logic [2:0] m1_Lsel;
  logic [1:0] m1_Ssel;
  logic       m1_Jump, m1_Branch, m1_MemRead, m1_MemtoReg, m1_MemWrite;
  logic       m1_ALUSrc, m1_RegWrite, m1_WriteDataSel;
  logic [4:0] m1_DestReg;
  logic       m1_PCWrite, m1_IFIDWrite, m1_IFIDFlush, m1_EXHold;

  logic [20:0] ex_all;
  logic [3:0]  haz;
  assign ex_all = {EX_RegDst, EX_ALUOp, EX_Lsel, EX_Ssel, EX_Jump, EX_Branch, EX_MemRead,
                   EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite, EX_WriteDataSel};
  assign haz = {PCWrite, IFIDWrite, IFIDFlush, EXHold};

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  pipe_ctrl_unit #(.ALUOP_W(6), .REG_W(5), .MUL_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .InstructionOp(InstructionOp),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .BranchTaken(BranchTaken),
    .EX_RegDst(EX_RegDst), .EX_ALUOp(EX_ALUOp), .EX_Lsel(EX_Lsel), .EX_Ssel(EX_Ssel),
    .EX_Jump(EX_Jump), .EX_Branch(EX_Branch), .EX_MemRead(EX_MemRead),
    .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc),
    .EX_RegWrite(EX_RegWrite), .EX_WriteDataSel(EX_WriteDataSel), .EX_DestReg(EX_DestReg),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .EXHold(EXHold)
  );

  pipe_ctrl_unit #(.ALUOP_W(6), .REG_W(5), .MUL_CYCLES(1)) dut_m1 (
    .Clk(Clk), .Rst(Rst), .InstructionOp(InstructionOp),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .BranchTaken(BranchTaken),
    .EX_RegDst(m1_RegDst), .EX_ALUOp(m1_ALUOp), .EX_Lsel(m1_Lsel), .EX_Ssel(m1_Ssel),
    .EX_Jump(m1_Jump), .EX_Branch(m1_Branch), .EX_MemRead(m1_MemRead),
    .EX_MemtoReg(m1_MemtoReg), .EX_MemWrite(m1_MemWrite), .EX_ALUSrc(m1_ALUSrc),
    .EX_RegWrite(m1_RegWrite), .EX_WriteDataSel(m1_WriteDataSel), .EX_DestReg(m1_DestReg),
    .PCWrite(m1_PCWrite), .IFIDWrite(m1_IFIDWrite), .IFIDFlush(m1_IFIDFlush), .EXHold(m1_EXHold)
  );

  // Decode table: {RegDst, ALUOp, Lsel, Ssel, Jump, Branch, MemRead, MemtoReg,
  // MemWrite, ALUSrc, RegWrite, WriteDataSel}
  localparam int NDEC = 22;
  localparam logic [5:0] DEC_OP [NDEC] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
    6'b001111, 6'b100000, 6'b100001, 6'b100100, 6'b100101, 6'b101000, 6'b101001,
    6'b101011, 6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
    6'b001110};
  localparam logic [20:0] DEC_EXP [NDEC] = '{
    21'b01_000010_000_00_00000010,
    21'b00_100001_000_00_01000000,
    21'b00_000000_000_00_10000000,
    21'b10_000000_000_00_10000011,
    21'b00_100011_000_00_01000000,
    21'b00_100100_000_00_01000000,
    21'b00_100101_000_00_01000000,
    21'b00_100110_000_00_00000110,
    21'b00_001000_010_00_00110110,
    21'b00_001000_001_00_00110110,
    21'b00_001000_100_00_00110110,
    21'b00_001000_011_00_00110110,
    21'b00_001000_000_10_00001100,
    21'b00_001000_000_01_00001100,
    21'b00_001000_000_00_00001100,
    21'b00_000100_000_00_00000110,
    21'b00_001000_000_00_00000110,
    21'b00_000110_000_00_00000110,
    21'b00_001010_000_00_00000110,
    21'b00_001001_000_00_00000110,
    21'b00_001011_000_00_00000110,
    21'b00_000111_000_00_00000110};

  localparam logic [20:0] EXP_LW   = 21'b00_001000_000_00_00110110;
  localparam logic [20:0] EXP_ADD  = 21'b01_000010_000_00_00000010;
  localparam logic [20:0] EXP_BEQ  = 21'b00_100010_000_00_01000000;
  localparam logic [20:0] EXP_JAL  = 21'b10_000000_000_00_10000011;
  localparam logic [20:0] EXP_J    = 21'b00_000000_000_00_10000000;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    InstructionOp = op;
    ID_Rs = rs;
    ID_Rt = rt;
    ID_Rd = rd;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    BranchTaken = 1'b0;
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    step();
    step();
    total_cnt++;
    if (ex_all !== 21'd0) $display("FAIL reset_ex_bundle got=%h want=%h", ex_all, 21'd0);
    else pass_cnt++;
    total_cnt++;
    if (EX_DestReg !== 5'd0) $display("FAIL reset_destreg got=%0d want=0", EX_DestReg);
    else pass_cnt++;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL reset_hazard got=%b want=1100", haz);
    else pass_cnt++;
    Rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_lw();
    set_id(6'b100011, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    #1;
    total_cnt++;
    if (ex_all !== EXP_LW) $display("FAIL lw_bundle got=%h want=%h", ex_all, EXP_LW);
    else pass_cnt++;
    total_cnt++;
    if (EX_DestReg !== 5'd5) $display("FAIL lw_destreg got=%0d want=5", EX_DestReg);
    else pass_cnt++;
    total_cnt++;
    if (PCWrite !== 1'b1) $display("FAIL lw_pcwrite got=%b want=1", PCWrite);
    else pass_cnt++;
    step();
    $display("test_lw done");
  endtask

  task automatic test_load_use();
    // lw $5 followed by add using $5 as rs
    set_id(6'b100011, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b000000, 5'd5, 5'd6, 5'd7);
    #1;
    total_cnt++;
    if (haz !== 4'b0000) $display("FAIL lu_rs_stall got=%b want=0000", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== 21'd0) $display("FAIL lu_bubble got=%h want=0", ex_all);
    else pass_cnt++;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL lu_release got=%b want=1100", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== EXP_ADD) $display("FAIL lu_add_enters got=%h want=%h", ex_all, EXP_ADD);
    else pass_cnt++;
    total_cnt++;
    if (EX_DestReg !== 5'd7) $display("FAIL lu_add_dest got=%0d want=7", EX_DestReg);
    else pass_cnt++;
    // store reads rt
    set_id(6'b100011, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b101011, 5'd2, 5'd5, 5'd0);
    #1;
    total_cnt++;
    if (haz !== 4'b0000) $display("FAIL lu_sw_rt_stall got=%b want=0000", haz);
    else pass_cnt++;
    step();
    step();
    // addi's rt is a destination, not a source
    set_id(6'b100011, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b001000, 5'd2, 5'd5, 5'd0);
    #1;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL lu_addi_rt_nostall got=%b want=1100", haz);
    else pass_cnt++;
    // load to $0
    set_id(6'b100011, 5'd0, 5'd0, 5'd0);
    step();
    set_id(6'b000000, 5'd0, 5'd0, 5'd3);
    #1;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL lu_dest0_nostall got=%b want=1100", haz);
    else pass_cnt++;
    step();
    $display("test_load_use done");
  endtask

  task automatic test_mul();
    set_id(6'b011100, 5'd1, 5'd2, 5'd3);
    step();
    set_id(6'b000000, 5'd1, 5'd2, 5'd8);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) BranchTaken = 1'b1;
      #1;
      total_cnt++;
      if (haz !== 4'b0001) $display("FAIL mul_stall_c%0d got=%b want=0001", k, haz);
      else pass_cnt++;
      total_cnt++;
      if (EX_ALUOp !== 6'b000101) $display("FAIL mul_hold_c%0d got=%b want=000101", k, EX_ALUOp);
      else pass_cnt++;
      if (k == 0) begin
        total_cnt++;
        if ({m1_PCWrite, m1_EXHold, m1_ALUOp} !== {1'b1, 1'b0, 6'b000101})
          $display("FAIL mul1_nostall got=%b%b_%b want=10_000101", m1_PCWrite, m1_EXHold, m1_ALUOp);
        else pass_cnt++;
      end
      if (k == 1) begin
        total_cnt++;
        if (m1_ALUOp !== 6'b000010) $display("FAIL mul1_next got=%b want=000010", m1_ALUOp);
        else pass_cnt++;
      end
      step();
      BranchTaken = 1'b0;
    end
    #1;
    total_cnt++;
    if (EX_ALUOp !== 6'b000101) $display("FAIL mul_last_cycle got=%b want=000101", EX_ALUOp);
    else pass_cnt++;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL mul_done got=%b want=1100", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== EXP_ADD) $display("FAIL mul_follow got=%h want=%h", ex_all, EXP_ADD);
    else pass_cnt++;
    $display("test_mul done");
  endtask

  task automatic test_branch_jump();
    set_id(6'b000100, 5'd1, 5'd2, 5'd0);
    step();
    total_cnt++;
    if (ex_all !== EXP_BEQ) $display("FAIL beq_bundle got=%h want=%h", ex_all, EXP_BEQ);
    else pass_cnt++;
    set_id(6'b001000, 5'd3, 5'd4, 5'd0);
    BranchTaken = 1'b1;
    #1;
    total_cnt++;
    if (haz !== 4'b1110) $display("FAIL br_flush got=%b want=1110", haz);
    else pass_cnt++;
    step();
    BranchTaken = 1'b0;
    total_cnt++;
    if (ex_all !== 21'd0) $display("FAIL br_bubble got=%h want=0", ex_all);
    else pass_cnt++;
    set_id(6'b000011, 5'd0, 5'd0, 5'd0);
    #1;
    total_cnt++;
    if (haz !== 4'b1110) $display("FAIL jal_flush got=%b want=1110", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== EXP_JAL) $display("FAIL jal_bundle got=%h want=%h", ex_all, EXP_JAL);
    else pass_cnt++;
    total_cnt++;
    if (EX_DestReg !== 5'd31) $display("FAIL jal_dest got=%0d want=31", EX_DestReg);
    else pass_cnt++;
    $display("test_branch_jump done");
  endtask

  task automatic test_back_to_back();
    // load-use beats a jump in ID; the jump decodes again once the stall clears
    set_id(6'b100011, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b000010, 5'd5, 5'd0, 5'd0);
    #1;
    total_cnt++;
    if (haz !== 4'b0000) $display("FAIL lu_over_jump got=%b want=0000", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (haz !== 4'b1110) $display("FAIL jump_redecode got=%b want=1110", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== EXP_J) $display("FAIL jump_bundle got=%h want=%h", ex_all, EXP_J);
    else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_mul();
    set_id(6'b011100, 5'd1, 5'd2, 5'd3);
    step();
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    step();
    Rst = 1'b1;
    #1;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL rst_mid_mul_haz got=%b want=1100", haz);
    else pass_cnt++;
    step();
    Rst = 1'b0;
    #1;
    total_cnt++;
    if (ex_all !== 21'd0) $display("FAIL rst_mid_mul_ex got=%h want=0", ex_all);
    else pass_cnt++;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL rst_mid_mul_after got=%b want=1100", haz);
    else pass_cnt++;
    $display("test_reset_mid_mul done");
  endtask

  task automatic test_unknown();
    set_id(6'b111111, 5'd4, 5'd4, 5'd4);
    #1;
    total_cnt++;
    if (haz !== 4'b1100) $display("FAIL unk_haz got=%b want=1100", haz);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== 21'd0) $display("FAIL unk_bundle got=%h want=0", ex_all);
    else pass_cnt++;
    $display("test_unknown done");
  endtask

  task automatic test_decode();
    logic [20:0] e;
    logic [4:0]  d;
    for (int i = 0; i < NDEC; i++) begin
      set_id(DEC_OP[i], 5'd1, 5'd0, 5'd9);
      step();
      e = DEC_EXP[i];
      d = (e[20:19] == 2'b01) ? 5'd9 : (e[20:19] == 2'b10) ? 5'd31 : 5'd0;
      total_cnt++;
      if (ex_all !== e) $display("FAIL decode_%b got=%h want=%h", DEC_OP[i], ex_all, e);
      else pass_cnt++;
      total_cnt++;
      if (EX_DestReg !== d) $display("FAIL decode_dest_%b got=%0d want=%0d", DEC_OP[i], EX_DestReg, d);
      else pass_cnt++;
      $display("decode op=%b ex=%h dest=%0d", DEC_OP[i], ex_all, EX_DestReg);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_use();
    test_mul();
    test_branch_jump();
    test_back_to_back();
    test_reset_mid_mul();
    test_unknown();
    test_decode();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the combinational main-control decoder for the 5-stage MIPS pipeline.
- Decodes the ID-stage opcode and registers the control bundle into the ID/EX control register.
- Owns hazard control: load-use stall, taken-branch/jump flush, and a parametrised multi-cycle multiply stall.
- Drives the PC, IF/ID and EX-hold enables.

Parameters:
- ALUOP_W, 6: ALUOp width.
- REG_W, 5: register-address width.
- MUL_CYCLES, 4: EX occupancy of op 011100 (mul/clo/clz), legal 1..16.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- InstructionOp  in  6  ID-stage opcode.
- ID_Rs  in  REG_W  ID-stage rs field.
- ID_Rt  in  REG_W  ID-stage rt field.
- ID_Rd  in  REG_W  ID-stage rd field.
- BranchTaken  in  1  EX-stage branch resolved taken.
- EX_RegDst  out  2  00=rt, 01=rd, 10=r31.
- EX_ALUOp  out  ALUOP_W  ALU operation.
- EX_Lsel  out  3  load size/sign select.
- EX_Ssel  out  2  store size select.
- EX_Jump, EX_Branch, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite, EX_WriteDataSel  out  1 each  registered control.
- EX_DestReg  out  REG_W  resolved write register (rt/rd/31).
- PCWrite  out  1  PC enable.
- IFIDWrite  out  1  IF/ID enable.
- IFIDFlush  out  1  clear IF/ID next edge.
- EXHold  out  1  downstream ID/EX datapath register holds.

Behaviour:
- Decode is combinational on InstructionOp with the existing opcode map:
  - 000000: R-type, ALUOp 000010, RegDst 01.
  - 000001: bgez/bltz, 100001.
  - 000010: j.
  - 000011: jal, RegDst 10, WriteDataSel 1.
  - 000100: beq 100010; 000101: bne 100011; 000110: blez 100100; 000111: bgtz 100101.
  - 001111: lui 100110.
  - Loads use ALUOp 001000 with Lsel lb 010 / lh 001 / lw 000 / lbu 100 / lhu 011.
  - Stores use ALUOp 001000 with Ssel sb 10 / sh 01 / sw 00.
  - Immediates: addi 000100, addiu 001000, slti 000110, sltiu 001010, andi 001001, ori 001011, xori 000111.
  - 011100: RegDst 01, ALUOp 000101.
  - Unknown opcode: all-zero bundle (bubble).
- ID/EX control register: 1-cycle latency from ID decode to EX_* outputs. All EX_* reset to 0.
- Reset values: PCWrite=1, IFIDWrite=1, IFIDFlush=0, EXHold=0, mul counter=0.
- UsesRt(op) is true for R-type, beq, bne, stores, and 011100.
- Priority each cycle, highest first:
  1. Rst: apply reset values.
  2. BranchTaken (and !MulBusy): ID/EX loads bubble. IFIDFlush=1. PCWrite=1.
  3. MulBusy (counter!=0): ID/EX holds. EXHold=1. PCWrite=IFIDWrite=0. Counter decrements.
  4. LoadUse: EX_MemRead & EX_DestReg!=0 & (EX_DestReg==ID_Rs | (UsesRt & EX_DestReg==ID_Rt)). ID/EX loads bubble. PCWrite=IFIDWrite=0.
  5. Normal: ID/EX loads the decoded bundle. If the decoded Jump=1, IFIDFlush=1 (one delay-slot kill).
- Multiply timing:
  - When op 011100 enters ID/EX, the counter loads MUL_CYCLES-1.
  - MUL_CYCLES=1 gives no stall.
  - The multiply remains in EX for exactly MUL_CYCLES cycles.
- Bubble means every control bit 0 and ALUOp 0. EX_DestReg is still registered.
- EX_DestReg=0 never causes a stall.
- BranchTaken asserted while MulBusy is impossible by construction; MulBusy wins and BranchTaken is ignored.
- Reset mid-stall clears the counter and bubbles ID/EX within the same edge.
- Load-use and jump in ID in the same cycle: the stall wins; the jump re-decodes next cycle.
- Hazard outputs are combinational from registered state plus ID inputs.

Decomposition:
- Package ctrl_pkg:
  - opcode constants (OP_RTYPE, OP_LW, ...).
  - ALUOp codes.
  - Lsel/Ssel/RegDst encodings.
  - the ctrl_bundle_t struct.
  - the BUBBLE constant.
- Sub-module ctrl_decode: pure combinational opcode→ctrl_bundle_t plus UsesRt.
- pipe_ctrl_unit: registers, counter, hazard logic.

Test Plan:
- Reset, then lw (100011): next cycle EX_MemRead=1, EX_MemtoReg=1, EX_ALUSrc=1, EX_RegWrite=1, ALUOp=001000, Lsel=000. PCWrite=1.
- lw $5 in EX, add with ID_Rs=5 in ID: PCWrite=IFIDWrite=0 for 1 cycle, then EX gets a bubble, then the add.
  - Repeat with EX_DestReg=0: no stall.
- mul (011100) with MUL_CYCLES=4: EXHold=1 and PCWrite=0 for 3 cycles; EX_ALUOp=000101 held for 4 cycles.
  - MUL_CYCLES=1: no stall.
- beq in EX with BranchTaken=1: IFIDFlush=1, next EX bundle all-zero. jal in ID: next EX_RegDst=10, WriteDataSel=1, IFIDFlush=1.
- Rst asserted during the 2nd mul stall cycle: next edge all EX_*=0, PCWrite=1, EXHold=0.
- Unknown opcode 111111: EX bundle all-zero, no stall, PCWrite=1.
